// File: rtl/fsic_cfg_arbiter.sv
// fsic_cfg_arbiter: round-robin share of the AXI-Lite config port between the
// management SoC path (m0) and the remote serdes path (m1), with response timeout.
module fsic_cfg_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_ack,
    output logic [31:0]           m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_ack,
    output logic [31:0]           m1_rdata,
    output logic                  m1_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                state, state_n;
    logic                  last_grant, gnt, gnt_n, res_err, timeout;
    logic [15:0]           cnt, cnt_n;
    logic [31:0]           res_data;
    logic [ADDR_WIDTH-1:0] addr;

    assign awaddr = addr;
    assign araddr = addr;

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        cnt_n    = cnt + 16'd1;
        res_data = '0;
        res_err  = 1'b0;
        timeout  = state != IDLE && state != DONE && cnt + 16'd1 == 16'(TIMEOUT);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (m0_req || m1_req) begin
                    gnt_n   = (m0_req && m1_req) ? !last_grant : m1_req;
                    state_n = (gnt_n ? m1_we : m0_we) ? WR_ADDR : RD_ADDR;
                end
            end
            // a channel whose valid is already low has finished its handshake
            WR_ADDR: state_n = ((!awvalid || awready) && (!wvalid || wready)) ? WR_RESP : WR_ADDR;
            WR_RESP: if (bvalid) begin
                state_n = DONE;
                res_err = bresp != 2'b00;
            end
            RD_ADDR: state_n = arready ? RD_DATA : RD_ADDR;
            RD_DATA: if (rvalid) begin
                state_n  = DONE;
                res_data = rdata;
                res_err  = rresp != 2'b00;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (timeout) begin
            state_n  = DONE;
            res_data = '1;
            res_err  = 1'b1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            arvalid    <= 1'b0;
            bready     <= 1'b1;
            rready     <= 1'b1;
            m0_ack     <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            if (state == DONE) last_grant <= gnt;
            if (state == IDLE) begin
                addr  <= gnt_n ? m1_addr : m0_addr;
                wdata <= gnt_n ? m1_wdata : m0_wdata;
                wstrb <= gnt_n ? m1_wstrb : m0_wstrb;
            end
            awvalid <= state_n == WR_ADDR && (state == IDLE || (awvalid && !awready));
            wvalid  <= state_n == WR_ADDR && (state == IDLE || (wvalid && !wready));
            arvalid <= state_n == RD_ADDR;
            // ready in IDLE drains late responses from aborted transactions
            bready  <= state_n == IDLE || state_n == WR_RESP;
            rready  <= state_n == IDLE || state_n == RD_DATA;
            m0_ack  <= state_n == DONE && !gnt;
            m1_ack  <= state_n == DONE && gnt;
            if (state_n == DONE && !gnt) begin
                m0_rdata <= res_data;
                m0_err   <= res_err;
            end
            if (state_n == DONE && gnt) begin
                m1_rdata <= res_data;
                m1_err   <= res_err;
            end
        end
    end
endmodule

// File: tb/tb_fsic_cfg_arbiter.sv
// tb_fsic_cfg_arbiter: scoreboard bench with a configurable AXI-Lite slave model
// and two blocking requester tasks.
module tb_fsic_cfg_arbiter;
    logic        axi_clk = 1'b0, axi_reset_n = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 axi_clk = ~axi_clk;

    fsic_cfg_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          who;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    int   acks0 = 0, acks1 = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge axi_clk);
            if (m0_ack || m1_ack) begin
                if (m0_ack) acks0++;
                if (m1_ack) acks1++;
                if (sb.size() == 0) check("unexpected_ack", {m1_ack, m0_ack}, 2'b00);
                else begin
                    e = sb.pop_front();
                    check("ack_who", {m1_ack, m0_ack}, e.who != 0 ? 2'b10 : 2'b01);
                    check("ack_rdata", e.who != 0 ? m1_rdata : m0_rdata, e.rdata);
                    check("ack_err", e.who != 0 ? m1_err : m0_err, e.err);
                end
            end
        end
    end

    // slave model: readies after a per-channel delay (-1 = never), response one cycle after address/data
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    bit          inj_r = 0;
    int          aw_cnt, w_cnt, ar_cnt, r_wait, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, w_low_aw_high = 0;
    bit          b_pend, r_pend, aw_got, w_got, r_real;
    logic [31:0] got_awaddr, got_wdata, got_araddr;
    logic [3:0]  got_wstrb;

    initial begin
        {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} = '0;
        {aw_cnt, w_cnt, ar_cnt, r_wait} = '0;
        {b_pend, r_pend, aw_got, w_got, r_real} = '0;
        got_araddr = '0;
        forever begin
            @(negedge axi_clk);
            if (!axi_reset_n) begin
                {awready, wready, bvalid, arready, rvalid} = '0;
                {aw_cnt, w_cnt, ar_cnt, r_wait} = '0;
                {b_pend, r_pend, aw_got, w_got} = '0;
            end else begin
                bvalid = b_pend;
                bresp  = b_resp_cfg;
                r_real = r_pend && r_wait >= r_dly;
                if (r_real) begin
                    rvalid = 1'b1;
                    rdata  = {8{got_araddr[11:8]}};
                    rresp  = r_resp_cfg;
                end else begin
                    rvalid = inj_r;
                    rdata  = 32'hDEAD_BEEF;
                    rresp  = 2'b00;
                    if (r_pend) r_wait++;
                end
                inj_r   = 0;
                awready = awvalid && aw_dly >= 0 && aw_cnt >= aw_dly;
                wready  = wvalid && w_dly >= 0 && w_cnt >= w_dly;
                arready = arvalid && ar_dly >= 0 && ar_cnt >= ar_dly;
                if (awvalid && !wvalid) w_low_aw_high++;
                if (bvalid && bready) begin
                    b_hs++;
                    b_pend = 0;
                end
                if (awvalid && awready) begin
                    aw_hs++;
                    aw_cnt = 0;
                    got_awaddr = awaddr;
                    aw_got = 1;
                end else if (awvalid) aw_cnt++;
                if (wvalid && wready) begin
                    w_hs++;
                    w_cnt = 0;
                    got_wdata = wdata;
                    got_wstrb = wstrb;
                    w_got = 1;
                end else if (wvalid) w_cnt++;
                if (aw_got && w_got) begin
                    b_pend = 1;
                    {aw_got, w_got} = 2'b00;
                end
                if (rvalid && rready) begin
                    r_hs++;
                    if (r_real) r_pend = 0;
                end
                if (arvalid && arready) begin
                    ar_hs++;
                    ar_cnt = 0;
                    got_araddr = araddr;
                    r_pend = 1;
                    r_wait = 0;
                end else if (arvalid) ar_cnt++;
            end
        end
    end

    // lat = negedges from raising req (DUT idle) until the ack is seen
    task automatic txn(input int who, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, output int lat);
        @(negedge axi_clk);
        if (who == 0) {m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb} = {1'b1, we, addr, wd, ws};
        else          {m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb} = {1'b1, we, addr, wd, ws};
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge axi_clk);
            if (who == 0 ? m0_ack : m1_ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("ack_wait", who == 0 ? m0_ack : m1_ack, 1'b1);
        if (who == 0) m0_req = 1'b0;
        else m1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int l0, l1, a0, a1, s_aw, s_w, s_b, s_low, s_r;

    initial begin
        {m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb} = '0;
        {m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb} = '0;
        repeat (3) @(negedge axi_clk);
        check("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("rst_readies", {bready, rready}, 2'b11);
        check("rst_m0", {m0_ack, m0_err, m0_rdata}, 34'd0);
        check("rst_m1", {m1_ack, m1_err, m1_rdata}, 34'd0);
        axi_reset_n = 1'b1;

        // tie from reset alternates m0, m1, m0, m1
        sb.push_back('{0, 32'h1111_1111, 1'b0});
        sb.push_back('{1, 32'h2222_2222, 1'b0});
        sb.push_back('{0, 32'h1111_1111, 1'b0});
        sb.push_back('{1, 32'h2222_2222, 1'b0});
        fork
            begin txn(0, 0, 32'h100, 0, 0, l0); txn(0, 0, 32'h100, 0, 0, l0); end
            begin txn(1, 0, 32'h200, 0, 0, l1); txn(1, 0, 32'h200, 0, 0, l1); end
        join
        check("rr_drained", sb.size(), 0);

        a1 = acks1;
        sb.push_back('{0, 32'h0, 1'b0});
        txn(0, 1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, l0);
        check("wr_latency", l0, 3);
        check("wr_awaddr", got_awaddr, 32'h3000_0010);
        check("wr_wdata", got_wdata, 32'hA5A5_1234);
        check("wr_wstrb", got_wstrb, 4'hF);
        check("wr_m1_quiet", acks1 - a1, 0);

        aw_dly = 3;
        w_dly = 1;
        {s_aw, s_w, s_b, s_low} = {aw_hs, w_hs, b_hs, w_low_aw_high};
        sb.push_back('{1, 32'h0, 1'b0});
        txn(1, 1, 32'h3000_0020, 32'h0BAD_F00D, 4'h3, l1);
        check("dly_latency", l1, 6);
        check("dly_aw_hs", aw_hs - s_aw, 1);
        check("dly_w_hs", w_hs - s_w, 1);
        check("dly_b_hs", b_hs - s_b, 1);
        check("dly_w_low_aw_high", w_low_aw_high - s_low, 2);
        check("dly_wdata", {got_wdata, got_wstrb}, {32'h0BAD_F00D, 4'h3});
        aw_dly = 0;
        w_dly = 0;

        b_resp_cfg = 2'b01;
        sb.push_back('{0, 32'h0, 1'b1});
        txn(0, 1, 32'h3000_0040, 32'h1, 4'h1, l0);
        b_resp_cfg = 2'b00;

        ar_dly = -1;
        sb.push_back('{1, 32'hFFFF_FFFF, 1'b1});
        txn(1, 0, 32'h200, 0, 0, l1);
        check("to_latency", l1, 9);
        check("to_arvalid", arvalid, 1'b0);
        ar_dly = 0;
        @(posedge axi_clk);
        {s_r, a0, a1} = {r_hs, acks0, acks1};
        inj_r = 1;
        repeat (4) @(negedge axi_clk);
        check("stale_r_consumed", r_hs - s_r, 1);
        check("stale_no_ack", (acks0 - a0) + (acks1 - a1), 0);

        r_resp_cfg = 2'b10;
        sb.push_back('{0, 32'h3333_3333, 1'b1});
        txn(0, 0, 32'h300, 0, 0, l0);
        r_resp_cfg = 2'b00;

        r_dly = 5;
        @(negedge axi_clk);
        {m0_req, m0_we, m0_addr} = {1'b1, 1'b0, 32'h100};
        repeat (2) @(negedge axi_clk);
        check("mid_rd_data", {arvalid, rready, m0_ack}, 3'b010);
        #1 axi_reset_n = 1'b0;
        #1;
        check("arst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        check("arst_readies", {bready, rready}, 2'b11);
        check("arst_m0", {m0_ack, m0_err, m0_rdata}, 34'd0);
        check("arst_m1", {m1_ack, m1_err, m1_rdata}, 34'd0);
        m0_req = 1'b0;
        r_dly = 0;
        repeat (2) @(negedge axi_clk);
        axi_reset_n = 1'b1;
        sb.push_back('{0, 32'h1111_1111, 1'b0});
        sb.push_back('{1, 32'h0, 1'b0});
        fork
            txn(0, 0, 32'h100, 0, 0, l0);
            txn(1, 1, 32'h3000_0030, 32'h5, 4'h1, l1);
        join
        check("post_rst_latency_m0", l0, 3);
        repeat (3) @(negedge axi_clk);
        check("final_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
